// File: rtl/bubble_output_serializer.sv
// Bubble output serializer: turns timing-generator cycle numbers into buffer-RAM
// fetches and presents each fetched nibble on DOUT during the cycle's output tick.
module bubble_output_serializer #(
  parameter int ADDR_W     = 21,
  parameter int BOOT_WORDS = 4106,
  parameter int PAGE_WORDS = 584
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic [2:0]        ACCTYPE,
  input  logic [12:0]       BOUTCYCLENUM,
  input  logic [1:0]        BOUTTICKS,
  input  logic [11:0]       ABSPOS,
  output logic              RD_REQ,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic              RD_ACK,
  input  logic [3:0]        RD_DATA,
  output logic [3:0]        DOUT,
  output logic              UNDERRUN
);

  localparam logic [12:0]       CYC_NONE  = 13'h1FFF;
  localparam logic [2:0]        ACC_RST   = 3'b000;
  localparam logic [2:0]        ACC_USER  = 3'b111;
  localparam logic [1:0]        TICK_OUT  = 2'b10;
  localparam logic [ADDR_W-1:0] BOOT_BASE = ADDR_W'(BOOT_WORDS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t              state_r, state_nx_s;
  logic                rd_req_r, rd_req_nx_s;
  logic [ADDR_W-1:0]   rd_addr_r, rd_addr_nx_s;
  logic [3:0]          hold_r, hold_nx_s;
  logic                hold_valid_r, hold_valid_nx_s;
  logic                abort_r, abort_nx_s;
  logic                pend_r, pend_nx_s;
  logic                underrun_r, underrun_nx_s;
  logic [3:0]          dout_r, dout_nx_s;
  logic [12:0]         prev_cyc_r;
  logic [2:0]          prev_acc_r;
  logic [ADDR_W-1:0]   page_base_r;

  logic                active_s, is_user_s, user_entry_s, rst_entry_s;
  logic                cyc_valid_s, new_cyc_s, late_s;
  logic [ADDR_W-1:0]   abs_ext_s, cyc_ext_s, page_off_s, entry_base_s, base_s, fetch_addr_s;

  assign active_s     = ACCTYPE[1];
  assign is_user_s    = (ACCTYPE == ACC_USER);
  assign user_entry_s = is_user_s && (prev_acc_r != ACC_USER);
  assign rst_entry_s  = (ACCTYPE == ACC_RST) && (prev_acc_r != ACC_RST);
  assign cyc_valid_s  = active_s && (BOUTCYCLENUM != CYC_NONE);
  assign new_cyc_s    = cyc_valid_s && (BOUTCYCLENUM != prev_cyc_r);
  assign late_s       = cyc_valid_s && (BOUTTICKS == TICK_OUT) && !hold_valid_r;

  assign abs_ext_s = {{(ADDR_W-12){1'b0}}, ABSPOS};
  assign cyc_ext_s = {{(ADDR_W-13){1'b0}}, BOUTCYCLENUM};

  generate
    if (PAGE_WORDS == 584) begin : g_page_shift
      assign page_off_s = {abs_ext_s[ADDR_W-10:0], 9'b0} + {abs_ext_s[ADDR_W-7:0], 6'b0}
                        + {abs_ext_s[ADDR_W-4:0], 3'b0};
    end else begin : g_page_mul
      localparam logic [ADDR_W-1:0] PAGE_W = ADDR_W'(PAGE_WORDS);
      assign page_off_s = abs_ext_s * PAGE_W;
    end
  endgenerate

  // The entry cycle may also carry a new cycle number, so bypass the not-yet-latched base
  assign entry_base_s = BOOT_BASE + page_off_s;
  assign base_s       = user_entry_s ? entry_base_s : page_base_r;
  assign fetch_addr_s = is_user_s ? (base_s + cyc_ext_s) : cyc_ext_s;

  assign underrun_nx_s = !rst_entry_s &&
                         (underrun_r || late_s || ((state_r == S_REQ) && new_cyc_s));
  assign dout_nx_s     = (active_s && hold_valid_r && (BOUTTICKS == TICK_OUT)) ? hold_r : 4'b0000;

  // Fetch FSM next state and fetch bookkeeping
  always_comb begin
    state_nx_s      = state_r;
    rd_req_nx_s     = rd_req_r;
    rd_addr_nx_s    = rd_addr_r;
    hold_nx_s       = hold_r;
    hold_valid_nx_s = hold_valid_r;
    abort_nx_s      = abort_r;
    pend_nx_s       = pend_r;
    case (state_r)
      S_IDLE: begin
        if (new_cyc_s || (pend_r && cyc_valid_s)) begin
          state_nx_s      = S_REQ;
          rd_req_nx_s     = 1'b1;
          rd_addr_nx_s    = fetch_addr_s;
          hold_valid_nx_s = 1'b0;
          abort_nx_s      = 1'b0;
          pend_nx_s       = 1'b0;
        end else begin
          pend_nx_s = pend_r && active_s;
        end
      end
      S_REQ: begin
        // A request is never withdrawn; a superseded one completes and is then reissued
        pend_nx_s = (pend_r || new_cyc_s) && active_s;
        if (RD_ACK) begin
          state_nx_s  = S_IDLE;
          rd_req_nx_s = 1'b0;
          abort_nx_s  = 1'b0;
          if (abort_r || new_cyc_s || !active_s) begin
            hold_valid_nx_s = 1'b0;
          end else begin
            hold_nx_s       = RD_DATA;
            hold_valid_nx_s = 1'b1;
          end
        end else begin
          abort_nx_s = abort_r || new_cyc_s || !active_s;
        end
      end
      default: begin
        state_nx_s      = S_IDLE;
        rd_req_nx_s     = 1'b0;
        hold_valid_nx_s = 1'b0;
        abort_nx_s      = 1'b0;
        pend_nx_s       = 1'b0;
      end
    endcase
    hold_valid_nx_s = hold_valid_nx_s && active_s;
  end

  // FSM state register
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath, tracking and output registers
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      rd_req_r     <= 1'b0;
      rd_addr_r    <= '0;
      hold_r       <= 4'b0000;
      hold_valid_r <= 1'b0;
      abort_r      <= 1'b0;
      pend_r       <= 1'b0;
      underrun_r   <= 1'b0;
      dout_r       <= 4'b0000;
      prev_cyc_r   <= CYC_NONE;
      prev_acc_r   <= ACC_RST;
      page_base_r  <= '0;
    end else begin
      rd_req_r     <= rd_req_nx_s;
      rd_addr_r    <= rd_addr_nx_s;
      hold_r       <= hold_nx_s;
      hold_valid_r <= hold_valid_nx_s;
      abort_r      <= abort_nx_s;
      pend_r       <= pend_nx_s;
      underrun_r   <= underrun_nx_s;
      dout_r       <= dout_nx_s;
      prev_cyc_r   <= active_s ? BOUTCYCLENUM : CYC_NONE;
      prev_acc_r   <= ACCTYPE;
      page_base_r  <= user_entry_s ? entry_base_s : page_base_r;
    end
  end

  assign RD_REQ   = rd_req_r;
  assign RD_ADDR  = rd_addr_r;
  assign DOUT     = dout_r;
  assign UNDERRUN = underrun_r;

endmodule

// File: tb/tb_bubble_output_serializer.sv
// Directed bench for bubble_output_serializer: a vector table for the main flows
// plus hand-written sequences for underrun, reset-mid-request and boot wrap.
module tb_bubble_output_serializer;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic [2:0]  ACCTYPE;
  logic [12:0] BOUTCYCLENUM;
  logic [1:0]  BOUTTICKS;
  logic [11:0] ABSPOS;
  logic        RD_REQ;
  logic [20:0] RD_ADDR;
  logic        RD_ACK;
  logic [3:0]  RD_DATA;
  logic [3:0]  DOUT;
  logic        UNDERRUN;

  bubble_output_serializer dut (
    .MCLK(MCLK), .RESET(RESET), .ACCTYPE(ACCTYPE), .BOUTCYCLENUM(BOUTCYCLENUM),
    .BOUTTICKS(BOUTTICKS), .ABSPOS(ABSPOS), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR),
    .RD_ACK(RD_ACK), .RD_DATA(RD_DATA), .DOUT(DOUT), .UNDERRUN(UNDERRUN)
  );

  always #10 MCLK = ~MCLK;

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  acc;
    logic [12:0] cyc;
    logic [1:0]  tick;
    logic [11:0] abs;
    logic        ack;
    logic [3:0]  data;
    logic        exp_req;
    logic [20:0] exp_addr;
    logic [3:0]  exp_dout;
    logic        exp_und;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input string n, input logic rst, input logic [2:0] acc,
                              input logic [12:0] cyc, input logic [1:0] tick,
                              input logic [11:0] abs, input logic ack, input logic [3:0] data,
                              input logic er, input logic [20:0] ea, input logic [3:0] ed,
                              input logic eu);
    vec_t v;
    v.name = n; v.rst = rst; v.acc = acc; v.cyc = cyc; v.tick = tick; v.abs = abs;
    v.ack = ack; v.data = data; v.exp_req = er; v.exp_addr = ea; v.exp_dout = ed;
    v.exp_und = eu;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are held across one rising edge; outputs are sampled 1 time unit later
  task automatic apply(input vec_t v);
    RESET = v.rst; ACCTYPE = v.acc; BOUTCYCLENUM = v.cyc; BOUTTICKS = v.tick;
    ABSPOS = v.abs; RD_ACK = v.ack; RD_DATA = v.data;
    @(posedge MCLK);
    #1;
    check({v.name, ".req"}, {31'd0, RD_REQ}, {31'd0, v.exp_req});
    if (v.exp_req || v.rst) check({v.name, ".addr"}, {11'd0, RD_ADDR}, {11'd0, v.exp_addr});
    check({v.name, ".dout"}, {28'd0, DOUT}, {28'd0, v.exp_dout});
    check({v.name, ".und"}, {31'd0, UNDERRUN}, {31'd0, v.exp_und});
  endtask

  initial begin
    logic [12:0] cc;
    logic [3:0]  dd;
    logic [20:0] aa;

    RESET = 1'b1; ACCTYPE = 3'b000; BOUTCYCLENUM = 13'h1FFF; BOUTTICKS = 2'b11;
    ABSPOS = 12'd0; RD_ACK = 1'b0; RD_DATA = 4'h0;

    // Reset and idle in RST
    vecs.push_back(mk("rst0", 1'b1, 3'b000, 13'h1FFF, 2'b11, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b0));
    vecs.push_back(mk("rst1", 1'b1, 3'b000, 13'h1FFF, 2'b11, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b0));
    vecs.push_back(mk("rstacc_a", 1'b0, 3'b000, 13'd0, 2'b00, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b0));
    vecs.push_back(mk("rstacc_b", 1'b0, 3'b000, 13'd1, 2'b10, 12'd0, 1'b1, 4'hF, 1'b0, 21'd0, 4'h0, 1'b0));

    // BOOT cycles 0..3, ACK three clocks after REQ, nibble 8|cyc
    for (int c = 0; c < 4; c++) begin
      cc = 13'(c);
      dd = 4'h8 | 4'(c);
      aa = 21'(c);
      vecs.push_back(mk($sformatf("boot%0d_req", c),  1'b0, 3'b110, cc, 2'b00, 12'd0, 1'b0, 4'h0, 1'b1, aa, 4'h0, 1'b0));
      vecs.push_back(mk($sformatf("boot%0d_w1", c),   1'b0, 3'b110, cc, 2'b00, 12'd0, 1'b0, 4'h0, 1'b1, aa, 4'h0, 1'b0));
      vecs.push_back(mk($sformatf("boot%0d_w2", c),   1'b0, 3'b110, cc, 2'b01, 12'd0, 1'b0, 4'h0, 1'b1, aa, 4'h0, 1'b0));
      vecs.push_back(mk($sformatf("boot%0d_ack", c),  1'b0, 3'b110, cc, 2'b01, 12'd0, 1'b1, dd,   1'b0, 21'd0, 4'h0, 1'b0));
      vecs.push_back(mk($sformatf("boot%0d_t10a", c), 1'b0, 3'b110, cc, 2'b10, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, dd,   1'b0));
      vecs.push_back(mk($sformatf("boot%0d_t10b", c), 1'b0, 3'b110, cc, 2'b10, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, dd,   1'b0));
      vecs.push_back(mk($sformatf("boot%0d_t11", c),  1'b0, 3'b110, cc, 2'b11, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b0));
    end

    // USER entry at ABSPOS=10: base 4106+5840=9946; later ABSPOS changes are ignored
    vecs.push_back(mk("user5_req", 1'b0, 3'b111, 13'd5, 2'b00, 12'd10, 1'b0, 4'h0, 1'b1, 21'd9951, 4'h0, 1'b0));
    vecs.push_back(mk("user5_ack", 1'b0, 3'b111, 13'd5, 2'b01, 12'd10, 1'b1, 4'h6, 1'b0, 21'd0,    4'h0, 1'b0));
    vecs.push_back(mk("user5_t10", 1'b0, 3'b111, 13'd5, 2'b10, 12'd10, 1'b0, 4'h0, 1'b0, 21'd0,    4'h6, 1'b0));
    vecs.push_back(mk("user6_req", 1'b0, 3'b111, 13'd6, 2'b00, 12'd20, 1'b0, 4'h0, 1'b1, 21'd9952, 4'h0, 1'b0));
    vecs.push_back(mk("user6_ack", 1'b0, 3'b111, 13'd6, 2'b01, 12'd20, 1'b1, 4'hA, 1'b0, 21'd0,    4'h0, 1'b0));
    vecs.push_back(mk("user6_t10", 1'b0, 3'b111, 13'd6, 2'b10, 12'd20, 1'b0, 4'h0, 1'b0, 21'd0,    4'hA, 1'b0));
    vecs.push_back(mk("user6_t11", 1'b0, 3'b111, 13'd6, 2'b11, 12'd20, 1'b0, 4'h0, 1'b0, 21'd0,    4'h0, 1'b0));

    // SWAP and invalid cycle number: no request, no output
    vecs.push_back(mk("swap_t10",  1'b0, 3'b101, 13'd7,    2'b10, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b0));
    vecs.push_back(mk("boot_inv",  1'b0, 3'b110, 13'h1FFF, 2'b11, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b0));
    vecs.push_back(mk("boot_inv2", 1'b0, 3'b110, 13'h1FFF, 2'b11, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b0));

    foreach (vecs[i]) apply(vecs[i]);

    // ACK withheld past the next cycle change: underrun, stale nibble dropped, reissue for cycle 8
    apply(mk("ur_req7",   1'b0, 3'b111, 13'd7, 2'b00, 12'd10, 1'b0, 4'h0, 1'b1, 21'd9953, 4'h0, 1'b0));
    apply(mk("ur_wait",   1'b0, 3'b111, 13'd7, 2'b01, 12'd10, 1'b0, 4'h0, 1'b1, 21'd9953, 4'h0, 1'b0));
    apply(mk("ur_newcyc", 1'b0, 3'b111, 13'd8, 2'b00, 12'd10, 1'b0, 4'h0, 1'b1, 21'd9953, 4'h0, 1'b1));
    apply(mk("ur_t10",    1'b0, 3'b111, 13'd8, 2'b10, 12'd10, 1'b0, 4'h0, 1'b1, 21'd9953, 4'h0, 1'b1));
    apply(mk("ur_ackold", 1'b0, 3'b111, 13'd8, 2'b10, 12'd10, 1'b1, 4'hF, 1'b0, 21'd0,    4'h0, 1'b1));
    apply(mk("ur_reissue",1'b0, 3'b111, 13'd8, 2'b10, 12'd10, 1'b0, 4'h0, 1'b1, 21'd9954, 4'h0, 1'b1));
    apply(mk("ur_acknew", 1'b0, 3'b111, 13'd8, 2'b10, 12'd10, 1'b1, 4'h3, 1'b0, 21'd0,    4'h0, 1'b1));
    apply(mk("ur_out",    1'b0, 3'b111, 13'd8, 2'b10, 12'd10, 1'b0, 4'h0, 1'b0, 21'd0,    4'h3, 1'b1));
    apply(mk("ur_t11",    1'b0, 3'b111, 13'd8, 2'b11, 12'd10, 1'b0, 4'h0, 1'b0, 21'd0,    4'h0, 1'b1));

    // RESET while RD_REQ=1, then BOOT 4105 -> 0 wrap
    apply(mk("rm_req",    1'b0, 3'b110, 13'd4105, 2'b00, 12'd0, 1'b0, 4'h0, 1'b1, 21'd4105, 4'h0, 1'b1));
    apply(mk("rm_reset",  1'b1, 3'b110, 13'd4105, 2'b00, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0,    4'h0, 1'b0));
    apply(mk("wr_req",    1'b0, 3'b110, 13'd4105, 2'b00, 12'd0, 1'b0, 4'h0, 1'b1, 21'd4105, 4'h0, 1'b0));
    apply(mk("wr_ack",    1'b0, 3'b110, 13'd4105, 2'b01, 12'd0, 1'b1, 4'h2, 1'b0, 21'd0,    4'h0, 1'b0));
    apply(mk("wr_zero",   1'b0, 3'b110, 13'd0,    2'b00, 12'd0, 1'b0, 4'h0, 1'b1, 21'd0,    4'h0, 1'b0));
    apply(mk("wr_ack0",   1'b0, 3'b110, 13'd0,    2'b01, 12'd0, 1'b1, 4'h4, 1'b0, 21'd0,    4'h0, 1'b0));
    apply(mk("wr_out",    1'b0, 3'b110, 13'd0,    2'b10, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0,    4'h4, 1'b0));

    // ACK coincides with a new cycle: old data discarded, new request a cycle later
    apply(mk("sim_req1",  1'b0, 3'b110, 13'd1, 2'b00, 12'd0, 1'b0, 4'h0, 1'b1, 21'd1, 4'h0, 1'b0));
    apply(mk("sim_both",  1'b0, 3'b110, 13'd2, 2'b00, 12'd0, 1'b1, 4'h5, 1'b0, 21'd0, 4'h0, 1'b1));
    apply(mk("sim_req2",  1'b0, 3'b110, 13'd2, 2'b00, 12'd0, 1'b0, 4'h0, 1'b1, 21'd2, 4'h0, 1'b1));
    apply(mk("sim_ack2",  1'b0, 3'b110, 13'd2, 2'b10, 12'd0, 1'b1, 4'h7, 1'b0, 21'd0, 4'h0, 1'b1));
    apply(mk("sim_out",   1'b0, 3'b110, 13'd2, 2'b10, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h7, 1'b1));

    // UNDERRUN survives SWAP, clears on entry to RST
    apply(mk("und_swap",  1'b0, 3'b101, 13'h1FFF, 2'b11, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b1));
    apply(mk("und_rst",   1'b0, 3'b000, 13'h1FFF, 2'b11, 12'd0, 1'b0, 4'h0, 1'b0, 21'd0, 4'h0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
